// File: rtl/snake_dir_ctrl.sv
// snake_dir_ctrl: per-player direction controller for a snake game.
// Raw buttons are synchronized and debounced. Each press loads a pending
// request, and the request commits on the next unpaused game tick.
// Reversal requests are rejected at commit time.
//
// Per-player FSM (the state is the registered direction value itself):
//   state   | meaning
//   STOPPED | direction == 000, any pending request is accepted
//   MOVING  | direction != 000, reversals rejected, repeats consumed silently
module snake_dir_ctrl #(
  parameter int N_PLAYERS       = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [N_PLAYERS-1:0]   l,
  input  logic [N_PLAYERS-1:0]   r,
  input  logic [N_PLAYERS-1:0]   u,
  input  logic [N_PLAYERS-1:0]   d,
  input  logic                   tick,
  input  logic                   pause,
  input  logic                   clr,
  output logic [3*N_PLAYERS-1:0] direction,
  output logic [N_PLAYERS-1:0]   dir_chg,
  output logic [N_PLAYERS-1:0]   reject
);

  localparam logic [2:0] DIR_STOP  = 3'b000;
  localparam logic [2:0] DIR_LEFT  = 3'b001;
  localparam logic [2:0] DIR_RIGHT = 3'b010;
  localparam logic [2:0] DIR_UP    = 3'b011;
  localparam logic [2:0] DIR_DOWN  = 3'b100;

  // The counter only has to reach DEBOUNCE_CYCLES-1 before it clears.
  localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  // Button index 0..3 = l, r, u, d. This order is also the press priority.
  logic [3:0][N_PLAYERS-1:0] raw;
  logic [3:0][N_PLAYERS-1:0] sync1, sync2, deb, deb_d, press;
  logic [CW-1:0]             cnt [4][N_PLAYERS];

  logic [N_PLAYERS-1:0] sel_valid;
  logic [2:0]           sel_dir [N_PLAYERS];
  logic [N_PLAYERS-1:0] pvalid;
  logic [2:0]           pdir    [N_PLAYERS];
  logic [N_PLAYERS-1:0] commit;

  logic [2:0]           dir_q   [N_PLAYERS];
  logic [2:0]           dir_n   [N_PLAYERS];
  logic [N_PLAYERS-1:0] chg_q, chg_n, rej_q, rej_n;

  assign raw = {d, u, r, l};

  function automatic logic is_opposite(input logic [2:0] a, input logic [2:0] b);
    return ((a == DIR_LEFT) && (b == DIR_RIGHT)) || ((a == DIR_RIGHT) && (b == DIR_LEFT)) ||
           ((a == DIR_UP)   && (b == DIR_DOWN))  || ((a == DIR_DOWN)  && (b == DIR_UP));
  endfunction

  // Synchronize, debounce and edge-detect every button.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      deb   <= '0;
      deb_d <= '0;
      press <= '0;
      for (int b = 0; b < 4; b++)
        for (int i = 0; i < N_PLAYERS; i++)
          cnt[b][i] <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
      deb_d <= deb;
      press <= deb & ~deb_d;
      for (int b = 0; b < 4; b++) begin
        for (int i = 0; i < N_PLAYERS; i++) begin
          if (sync2[b][i] == deb[b][i]) begin
            cnt[b][i] <= '0;
          end else if (cnt[b][i] == CNT_LAST) begin
            deb[b][i] <= sync2[b][i];
            cnt[b][i] <= '0;
          end else begin
            cnt[b][i] <= cnt[b][i] + CW'(1);
          end
        end
      end
    end
  end

  // Resolve simultaneous presses of one player by priority l > r > u > d.
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      sel_valid[i] = 1'b1;
      sel_dir[i]   = DIR_STOP;
      if (press[0][i])      sel_dir[i] = DIR_LEFT;
      else if (press[1][i]) sel_dir[i] = DIR_RIGHT;
      else if (press[2][i]) sel_dir[i] = DIR_UP;
      else if (press[3][i]) sel_dir[i] = DIR_DOWN;
      else                  sel_valid[i] = 1'b0;
      commit[i] = tick & ~pause & pvalid[i];
    end
  end

  // Pending request: a new press wins over the commit that consumes the old one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pvalid <= '0;
      for (int i = 0; i < N_PLAYERS; i++) pdir[i] <= DIR_STOP;
    end else begin
      for (int i = 0; i < N_PLAYERS; i++) begin
        if (clr) begin
          pvalid[i] <= 1'b0;
        end else if (sel_valid[i]) begin
          pvalid[i] <= 1'b1;
          pdir[i]   <= sel_dir[i];
        end else if (commit[i]) begin
          pvalid[i] <= 1'b0;
        end
      end
    end
  end

  // FSM state register: direction plus the registered pulses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      chg_q <= '0;
      rej_q <= '0;
      for (int i = 0; i < N_PLAYERS; i++) dir_q[i] <= DIR_STOP;
    end else begin
      chg_q <= chg_n;
      rej_q <= rej_n;
      for (int i = 0; i < N_PLAYERS; i++) dir_q[i] <= dir_n[i];
    end
  end

  // FSM next state: clear first, then the commit decision.
  always_comb begin
    for (int i = 0; i < N_PLAYERS; i++) begin
      dir_n[i] = dir_q[i];
      chg_n[i] = 1'b0;
      rej_n[i] = 1'b0;
      if (clr) begin
        dir_n[i] = DIR_STOP;
      end else if (commit[i]) begin
        if (dir_q[i] == DIR_STOP) begin
          dir_n[i] = pdir[i];
          chg_n[i] = 1'b1;
        end else if (is_opposite(dir_q[i], pdir[i])) begin
          rej_n[i] = 1'b1;
        end else if (pdir[i] != dir_q[i]) begin
          dir_n[i] = pdir[i];
          chg_n[i] = 1'b1;
        end
      end
    end
  end

  // FSM outputs: drive the ports straight from the registers.
  always_comb begin
    direction = '0;
    for (int i = 0; i < N_PLAYERS; i++) direction[3*i +: 3] = dir_q[i];
    dir_chg = chg_q;
    reject  = rej_q;
  end

endmodule

// File: tb/tb_snake_dir_ctrl.sv
// Scoreboard bench for snake_dir_ctrl (N_PLAYERS=2, DEBOUNCE_CYCLES=4).
// The stimulus pushes one expected {direction, dir_chg, reject} for each
// tick/clr cycle that it marks. The monitor pops that entry and compares it.
module tb_snake_dir_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] lb = '0, rb = '0, ub = '0, db = '0;
  logic       tick = 1'b0, pause = 1'b0, clr = 1'b0;
  logic [5:0] direction;
  logic [1:0] dir_chg, reject;
  logic       chk = 1'b0;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [5:0] dir;
    logic [1:0] chg;
    logic [1:0] rej;
    string      nm;
  } exp_t;
  exp_t q[$];

  snake_dir_ctrl #(.N_PLAYERS(2), .DEBOUNCE_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .l(lb), .r(rb), .u(ub), .d(db),
    .tick(tick), .pause(pause), .clr(clr),
    .direction(direction), .dir_chg(dir_chg), .reject(reject)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, %0d expectations pending", q.size());
    $fatal(1, "watchdog");
  end

  // Monitor: compare after each marked cycle. Unmarked cycles must not pulse.
  initial begin : monitor
    exp_t e;
    logic c;
    forever begin
      @(posedge clk);
      c = chk;
      @(negedge clk);
      if (c) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL no_expectation: dir=%b chg=%b rej=%b with empty queue", direction, dir_chg, reject);
        end else begin
          e = q.pop_front();
          if (direction !== e.dir || dir_chg !== e.chg || reject !== e.rej) begin
            miscompares++;
            $display("FAIL %s: got dir=%b chg=%b rej=%b, want dir=%b chg=%b rej=%b",
                     e.nm, direction, dir_chg, reject, e.dir, e.chg, e.rej);
          end
        end
      end else if (dir_chg !== 2'b00 || reject !== 2'b00) begin
        miscompares++;
        $display("FAIL spurious_pulse: got chg=%b rej=%b, want 00 00", dir_chg, reject);
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apply(input logic t, input logic c, input logic [5:0] ed,
                       input logic [1:0] ec, input logic [1:0] er, input string nm);
    exp_t e;
    e.dir = ed; e.chg = ec; e.rej = er; e.nm = nm;
    q.push_back(e);
    tick = t; clr = c; chk = 1'b1;
    cyc(1);
    tick = 1'b0; clr = 1'b0; chk = 1'b0;
  endtask

  task automatic chk_now(input string nm);
    vectors++;
    if (direction !== 6'b0 || dir_chg !== 2'b0 || reject !== 2'b0) begin
      miscompares++;
      $display("FAIL %s: got dir=%b chg=%b rej=%b, want all zero", nm, direction, dir_chg, reject);
    end
  endtask

  // Hold long enough for the request to become pending, then release fully.
  task automatic press_btns(input logic [1:0] lm, input logic [1:0] rm,
                            input logic [1:0] um, input logic [1:0] dm);
    lb = lm; rb = rm; ub = um; db = dm;
    cyc(9);
    lb = '0; rb = '0; ub = '0; db = '0;
    cyc(8);
  endtask

  initial begin : stim
    #12;
    chk_now("reset_state");
    cyc(2);
    rst = 1'b0;
    cyc(2);

    // Press latency: rise before edge 1, press pulse at edge 7, pending at edge 8.
    lb = 2'b01;
    cyc(7);
    apply(1, 0, 6'b000_000, 2'b00, 2'b00, "latency_early_tick");
    apply(1, 0, 6'b000_001, 2'b01, 2'b00, "latency_commit_left");
    cyc(1);
    lb = 2'b00;
    cyc(8);
    apply(1, 0, 6'b000_001, 2'b00, 2'b00, "idle_tick");

    // Reversal is rejected. Turning is accepted. Repeating is silent.
    press_btns(2'b00, 2'b01, 2'b00, 2'b00);
    apply(1, 0, 6'b000_001, 2'b00, 2'b01, "reject_reversal");
    press_btns(2'b00, 2'b00, 2'b01, 2'b00);
    apply(1, 0, 6'b000_011, 2'b01, 2'b00, "turn_up");
    press_btns(2'b00, 2'b00, 2'b01, 2'b00);
    apply(1, 0, 6'b000_011, 2'b00, 2'b00, "same_dir_silent");

    // A 3-cycle glitch is ignored. A 4-cycle level is the shortest one accepted.
    lb = 2'b10;
    cyc(3);
    lb = 2'b00;
    cyc(10);
    apply(1, 0, 6'b000_011, 2'b00, 2'b00, "glitch_3cyc");
    lb = 2'b10;
    cyc(4);
    lb = 2'b00;
    cyc(10);
    apply(1, 0, 6'b001_011, 2'b10, 2'b00, "boundary_4cyc");

    // Last press wins. Priority applies between simultaneous presses.
    apply(0, 1, 6'b000_000, 2'b00, 2'b00, "clr_stop_all");
    press_btns(2'b00, 2'b00, 2'b01, 2'b00);
    press_btns(2'b00, 2'b00, 2'b00, 2'b01);
    apply(1, 0, 6'b000_100, 2'b01, 2'b00, "last_press_wins");
    press_btns(2'b01, 2'b01, 2'b10, 2'b10);
    apply(1, 0, 6'b011_001, 2'b11, 2'b00, "priority_lr_ud");

    // Pause holds the pending request.
    press_btns(2'b00, 2'b00, 2'b01, 2'b00);
    pause = 1'b1;
    for (int k = 0; k < 3; k++) begin
      apply(1, 0, 6'b011_001, 2'b00, 2'b00, "paused_tick");
      cyc(1);
    end
    pause = 1'b0;
    apply(1, 0, 6'b011_011, 2'b01, 2'b00, "unpause_commit");
    apply(0, 1, 6'b000_000, 2'b00, 2'b00, "clr_after_pause");
    apply(1, 0, 6'b000_000, 2'b00, 2'b00, "tick_after_clr");

    // Press and commit on the same edge: the old request commits, the new one waits.
    press_btns(2'b00, 2'b01, 2'b00, 2'b00);
    lb = 2'b01;
    cyc(7);
    apply(1, 0, 6'b000_010, 2'b01, 2'b00, "same_cycle_old_commit");
    apply(1, 0, 6'b000_010, 2'b00, 2'b01, "same_cycle_new_pending");
    lb = 2'b00;
    cyc(8);

    // clr wins over tick and drops the pending request.
    press_btns(2'b00, 2'b00, 2'b00, 2'b10);
    apply(1, 1, 6'b000_000, 2'b00, 2'b00, "clr_over_tick");
    apply(1, 0, 6'b000_000, 2'b00, 2'b00, "clr_dropped_pending");

    // Reset mid-debounce: outputs clear at once, and the held button re-debounces.
    press_btns(2'b00, 2'b00, 2'b10, 2'b00);
    apply(1, 0, 6'b011_000, 2'b10, 2'b00, "pre_reset_up");
    lb = 2'b01;
    cyc(4);
    #3 rst = 1'b1;
    #1 chk_now("async_reset_clears");
    cyc(3);
    rst = 1'b0;
    cyc(7);
    apply(1, 0, 6'b000_000, 2'b00, 2'b00, "post_reset_early_tick");
    apply(1, 0, 6'b000_001, 2'b01, 2'b00, "post_reset_press");
    lb = 2'b00;
    cyc(10);
    apply(1, 0, 6'b000_001, 2'b00, 2'b00, "post_reset_single_press");

    cyc(3);
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL queue_drain: %0d expectations left, want 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
